// File: rtl/afe_sram_wr_ctrl_if.sv
// Bus bundle for afe_sram_wr_ctrl: config, ADC stream, readout, SRAM pins.
// master = controller side, slave = environment. Optional smp_cnt_o under AFE_SRAM_WR_CTRL_CNT_EN.
`timescale 1ns/1ps
interface afe_sram_wr_ctrl_if #(
  parameter int ADC_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 10
);
  logic                      cfg_en_i;
  logic                      cfg_clr_i;
  logic                      cfg_oneshot_i;
  logic [ADDR_WIDTH-1:0]     cfg_last_addr_i;
  logic                      adc_valid_i;
  logic [ADC_DATA_WIDTH-1:0] adc_data_i;
  logic                      rd_req_i;
  logic [ADDR_WIDTH-1:0]     rd_addr_i;
  logic                      rd_gnt_o;
  logic                      rd_valid_o;
  logic [ADC_DATA_WIDTH-1:0] rd_data_o;
  logic                      sram_cen_o;
  logic                      sram_wen_o;
  logic [ADDR_WIDTH-1:0]     sram_addr_o;
  logic [ADC_DATA_WIDTH-1:0] sram_wdata_o;
  logic [ADC_DATA_WIDTH-1:0] sram_rdata_i;
  logic [ADDR_WIDTH-1:0]     wr_ptr_o;
  logic                      wrap_o;
  logic                      done_o;
  logic                      ovf_o;
  // Test hook: holds off SRAM writes so the sample FIFO can be filled.
  logic                      tst_stall_i;
`ifdef AFE_SRAM_WR_CTRL_CNT_EN
  logic [31:0]               smp_cnt_o;
`endif

  modport master (
    input  cfg_en_i, cfg_clr_i, cfg_oneshot_i, cfg_last_addr_i,
    input  adc_valid_i, adc_data_i, rd_req_i, rd_addr_i,
    input  sram_rdata_i, tst_stall_i,
    output rd_gnt_o, rd_valid_o, rd_data_o,
    output sram_cen_o, sram_wen_o, sram_addr_o, sram_wdata_o,
`ifdef AFE_SRAM_WR_CTRL_CNT_EN
    output smp_cnt_o,
`endif
    output wr_ptr_o, wrap_o, done_o, ovf_o
  );

  modport slave (
    output cfg_en_i, cfg_clr_i, cfg_oneshot_i, cfg_last_addr_i,
    output adc_valid_i, adc_data_i, rd_req_i, rd_addr_i,
    output sram_rdata_i, tst_stall_i,
    input  rd_gnt_o, rd_valid_o, rd_data_o,
    input  sram_cen_o, sram_wen_o, sram_addr_o, sram_wdata_o,
`ifdef AFE_SRAM_WR_CTRL_CNT_EN
    input  smp_cnt_o,
`endif
    input  wr_ptr_o, wrap_o, done_o, ovf_o
  );
endinterface

// File: rtl/afe_sram_wr_ctrl.sv
// ADC sample writer + readout arbiter for the per-channel SRAM ring buffer.
// Ports: clk_i, rst_ni (async low), bus (afe_sram_wr_ctrl_if.master). Macro AFE_SRAM_WR_CTRL_CNT_EN adds smp_cnt_o.
`timescale 1ns/1ps
module afe_sram_wr_ctrl #(
  parameter int ADC_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  afe_sram_wr_ctrl_if.master   bus
);
  localparam int DW = ADC_DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   fifo_q [2];
  logic            rd_idx_q, wr_idx_q;
  logic [1:0]      cnt_q;
  logic [AW-1:0]   wr_ptr_q;
  logic            wrap_q, ovf_q, rd_valid_q;

  logic fifo_empty, fifo_full;
  logic do_wr, do_rd;
  logic push_req, push, last_hit, to_done, ovf_set;

  assign fifo_empty = (cnt_q == 2'd0);
  assign fifo_full  = (cnt_q == 2'd2);

  // A full FIFO must drain now or the next sample is lost,
  // so it overrides a pending read.
  assign do_wr = rst_ni && !fifo_empty && !bus.tst_stall_i &&
                 (fifo_full || !bus.rd_req_i);
  assign do_rd = rst_ni && bus.rd_req_i && !do_wr;

  assign push_req = bus.adc_valid_i && (state_q == RUN) && bus.cfg_en_i;
  assign push     = push_req && (!fifo_full || do_wr);
  assign ovf_set  = push_req && fifo_full && !do_wr;
  // >= so that lowering the limit below the pointer still wraps.
  assign last_hit = do_wr && (wr_ptr_q >= bus.cfg_last_addr_i);
  assign to_done  = last_hit && bus.cfg_oneshot_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.cfg_clr_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (bus.cfg_en_i) state_d = RUN;
        RUN: begin
          if (to_done)           state_d = DONE;
          else if (!bus.cfg_en_i) state_d = DRAIN;
        end
        DRAIN: begin
          if (to_done)         state_d = DONE;
          else if (fifo_empty) state_d = IDLE;
        end
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.sram_cen_o   = 1'b1;
    bus.sram_wen_o   = 1'b1;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    bus.rd_gnt_o     = 1'b0;
    unique case (1'b1)
      do_wr: begin
        bus.sram_cen_o   = 1'b0;
        bus.sram_wen_o   = 1'b0;
        bus.sram_addr_o  = wr_ptr_q;
        bus.sram_wdata_o = fifo_q[rd_idx_q];
      end
      do_rd: begin
        bus.sram_cen_o  = 1'b0;
        bus.sram_addr_o = bus.rd_addr_i;
        bus.rd_gnt_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done_o     = (state_q == DONE);
  assign bus.wr_ptr_o   = wr_ptr_q;
  assign bus.wrap_o     = wrap_q;
  assign bus.ovf_o      = ovf_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_valid_q ? bus.sram_rdata_i : '0;

  // Entering DONE drops whatever is still queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_idx_q  <= 1'b0;
      wr_idx_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (bus.cfg_clr_i || to_done) begin
      rd_idx_q <= 1'b0;
      wr_idx_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_idx_q] <= bus.adc_data_i;
        wr_idx_q         <= ~wr_idx_q;
      end
      if (do_wr) rd_idx_q <= ~rd_idx_q;
      unique case ({push, do_wr})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.cfg_clr_i) begin
      wr_ptr_q <= '0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= last_hit ? '0 : wr_ptr_q + 1'b1;
      wrap_q <= last_hit && !bus.cfg_oneshot_i;
      ovf_q  <= ovf_q | ovf_set;
    end
  end

  // A granted read still returns data across a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_valid_q <= 1'b0;
    else         rd_valid_q <= do_rd;
  end

`ifdef AFE_SRAM_WR_CTRL_CNT_EN
  logic [31:0] smp_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             smp_cnt_q <= '0;
    else if (bus.cfg_clr_i)  smp_cnt_q <= '0;
    else if (do_wr)          smp_cnt_q <= smp_cnt_q + 32'd1;
  end
  assign bus.smp_cnt_o = smp_cnt_q;
`endif
endmodule

// File: doc/afe_sram_wr_ctrl.md
Name: afe_sram_wr_ctrl

Overview:
- Upstream controller for the per-channel SRAM sample buffer.
- Takes the free-running ADC sample stream, which has no back-pressure, and writes it into the buffer as a ring (continuous mode) or a single fill (one-shot mode).
- Arbitrates the single SRAM port between sample writes and readout requests from the uDMA/bus side.
- Drives the buffer's active-low cen/wen, address and data pins directly.

Parameters:
- ADC_DATA_WIDTH, 32, sample width; 1..32.
- ADDR_WIDTH, 10, SRAM word-address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cfg_en_i  in  1  capture enable (level).
- cfg_clr_i  in  1  synchronous clear pulse.
- cfg_oneshot_i  in  1  1 = stop after last address; 0 = ring.
- cfg_last_addr_i  in  ADDR_WIDTH  last buffer address used.
- adc_valid_i  in  1  sample strobe.
- adc_data_i  in  ADC_DATA_WIDTH  sample.
- rd_req_i  in  1  read request.
- rd_addr_i  in  ADDR_WIDTH  read address.
- rd_gnt_o  out  1  read accepted this cycle.
- rd_valid_o  out  1  rd_data_o valid.
- rd_data_o  out  ADC_DATA_WIDTH  read data.
- sram_cen_o  out  1  active-low SRAM enable.
- sram_wen_o  out  1  active-low SRAM write enable.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o  out  ADC_DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  ADC_DATA_WIDTH  SRAM read data.
- wr_ptr_o  out  ADDR_WIDTH  next write address.
- wrap_o  out  1  one-cycle pulse on ring wrap.
- done_o  out  1  one-shot fill complete (level).
- ovf_o  out  1  sticky: sample dropped.

Behaviour:
- Reset values:
  - sram_cen_o = 1, sram_wen_o = 1.
  - All other outputs 0.
  - FSM in IDLE; FIFO empty.
- Sample FIFO:
  - 2 entries.
  - Push when adc_valid_i and FSM is RUN with cfg_en_i = 1.
  - If the FIFO is full and not popped in the same cycle, the sample is dropped and ovf_o sets.
  - Push and pop in the same cycle while full is legal: no drop.
- FSM:
  - IDLE -> RUN when cfg_en_i = 1 and done_o = 0.
  - RUN -> DONE after the write to cfg_last_addr_i when cfg_oneshot_i = 1. Pushes stop; remaining FIFO entries are discarded; done_o = 1.
  - RUN -> DRAIN when cfg_en_i = 0. DRAIN writes the remaining FIFO entries, then goes to IDLE.
  - DONE holds until cfg_clr_i.
- Arbitration, per cycle, combinational onto the sram_* pins:
  - Write when FIFO non-empty AND (FIFO full OR rd_req_i = 0).
  - Otherwise, if rd_req_i, read.
  - Otherwise idle: cen = 1.
  - Write cycle: cen = 0, wen = 0, addr = wr_ptr, wdata = FIFO head.
  - Read cycle: cen = 0, wen = 1, addr = rd_addr_i, rd_gnt_o = 1.
- Read latency:
  - rd_valid_o is asserted 1 cycle after rd_gnt_o.
  - rd_data_o = sram_rdata_i in that cycle (passed through, not registered).
- Pointer:
  - Increments on each write.
  - When wr_ptr == cfg_last_addr_i, wraps to 0 and wrap_o pulses in the following cycle. This applies in ring mode only.
  - If cfg_last_addr_i is changed below wr_ptr, the next write still wraps, because the comparison is >=.
- cfg_clr_i:
  - Takes effect in the following cycle in any state.
  - Clears wr_ptr, the FIFO, done_o and ovf_o; FSM goes to IDLE.
  - An in-flight read still returns rd_valid_o.
  - Has priority over a simultaneous push or wrap.
- Reset asserted mid-write: outputs go to reset values immediately; SRAM contents are undefined at the interrupted address.

Optional Feature:
- Macro: AFE_SRAM_WR_CTRL_CNT_EN.
- Defined: adds output smp_cnt_o [31:0].
  - Counts samples actually written to the SRAM; wraps modulo 2^32.
  - Cleared by reset and by cfg_clr_i.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Ring fill: cfg_last_addr_i = 7, oneshot = 0, 10 samples 0x100..0x109, no reads -> addr 0..7 = 0x100..0x107, then addr 0 = 0x108, addr 1 = 0x109; wrap_o exactly once; wr_ptr_o = 2.
- One-shot: cfg_last_addr_i = 3, 6 samples -> 4 writes; done_o = 1; wr_ptr_o = 0; IDLE not re-entered until cfg_clr_i.
- Contention: adc_valid_i every cycle with rd_req_i held high -> writes every cycle once the FIFO is full; reads granted only in non-full gaps; ovf_o stays 0.
- Overflow: adc_valid_i every cycle for 3 cycles while the FIFO is stuck full (forced sram write stall via test hook) -> ovf_o = 1, sticky until cfg_clr_i.
- Readback: write 0xDEADBEEF at addr 5, then rd_req_i with addr 5 -> rd_gnt_o; next cycle rd_valid_o = 1, rd_data_o = 0xDEADBEEF.
- Clear/reset mid-run: cfg_clr_i during RUN with FIFO holding 2 entries -> no further writes; wr_ptr_o = 0; FSM in IDLE. Async rst_ni low mid-cycle -> sram_cen_o = 1 immediately.
